gate_bank_checker: RTL
======================

GATE_BANK_CHECKER -- requirements
Module: gate_bank_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: DUT settle cycles per vector; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 drive_a  output  1  A stimulus to gate bank under test.
REQ-006 drive_b  output  1  B stimulus to gate bank under test.
REQ-007 q_in  input  7  gate bank response; bit 0 AND, 1 OR, 2 NOT A, 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
REQ-008 busy  output  1  high from start acceptance through the last CHECK.
REQ-009 done  output  1  one-cycle pulse at run end.
REQ-010 pass  output  1  high when the last completed run had fail_mask == 0.
REQ-011 fail_mask  output  7  sticky OR of per-bit mismatches over the run.
REQ-012 err_cnt  output  3  count of vectors with any mismatch, 0..4.

Function
REQ-013 FSM states: IDLE, DRIVE, CHECK, DONE.
REQ-014 IDLE with start=1: next cycle DRIVE; vec=0; fail_mask, err_cnt, pass cleared.
REQ-015 Vector order vec 0..3; drive_a = vec[1], drive_b = vec[0]; outputs registered, stable for all of DRIVE and CHECK.
REQ-016 DRIVE lasts exactly SETTLE_CYCLES cycles, then CHECK for one cycle.
REQ-017 CHECK: mismatch = q_in XOR expected(drive_a, drive_b); fail_mask |= mismatch; err_cnt += 1 if mismatch != 0.
REQ-018 CHECK with vec<3: vec+1, go to DRIVE; with vec==3: go to DONE.
REQ-019 DONE lasts one cycle: done=1, pass=(fail_mask==0), busy=0; next state IDLE.
REQ-020 Latency: start sampled at cycle 0 -> done at cycle 4*(SETTLE_CYCLES+1)+1 (13 for default).
REQ-021 start outside IDLE ignored; no queuing. start held high reruns immediately: IDLE after DONE accepts it.
REQ-022 fail_mask, err_cnt and pass hold after DONE until the next accepted start.
REQ-023 err_cnt cannot exceed 4; no wrap logic required.
REQ-024 drive_a/drive_b return to 0 in IDLE.

Reset
REQ-025 rst_n low at any time, including mid-run: state IDLE, vec=0, and all outputs (drive_a, drive_b, busy, done, pass, fail_mask, err_cnt) 0 immediately and asynchronously.
REQ-026 First start accepted no earlier than the first clk edge after rst_n deasserts.

Configuration
REQ-027 Macro GBC_CAPTURE_EN defined: adds output first_fail (9 bits, {a,b,q_in}) latched at the first mismatching CHECK of a run, cleared on start and reset; first_valid (1 bit) flags it.
REQ-028 Macro undefined: first_fail/first_valid ports and logic absent; all other behaviour identical.

Structure
REQ-029 Package gbc_pkg holds: gate bit-index constants, FSM state typedef, vector-count constant (4), SETTLE_CYCLES bounds.
REQ-030 Sub-module gate_ref_model: combinational golden model, (a,b) -> 7-bit expected vector, same bit order as q_in.

Verification
REQ-031 Correct gate bank wired to drive_a/b, start at cycle 0 -> done at cycle 13, pass=1, fail_mask=7'h00, err_cnt=0.
REQ-032 q_in stuck at 7'h00 -> fail_mask=7'h7F, err_cnt=4, pass=0; with GBC_CAPTURE_EN, first_fail={0,0,7'h00}, first_valid=1.
REQ-033 XOR bit (bit 5) inverted -> fail_mask=7'h20, err_cnt=4, pass=0.
REQ-034 NOT bit forced to 1 -> fail_mask=7'h04, err_cnt=2 (vectors 2,3), pass=0.
REQ-035 start pulsed again at cycle 5 -> ignored, single done at cycle 13; start held high -> second done at cycle 27.
REQ-036 rst_n low at cycle 6 mid-run -> busy, drive_a/b, fail_mask, err_cnt 0 immediately, no done; a later start completes normally.

Source files
------------

// File: rtl/gbc_pkg.sv
// rtl/gbc_pkg.sv - shared constants and types for the gate bank checker
package gbc_pkg;

    // Bit positions of each gate response inside q_in and the expected vector
    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOTA = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;
    localparam int NUM_GATES = 7;

    // Exhaustive two-input stimulus: vectors 00, 01, 10, 11
    localparam int NUM_VECTORS = 4;

    // Legal range of the per-vector settle time
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } gbc_state_e;

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational golden response of the seven-gate bank
module gate_ref_model
    import gbc_pkg::*;
(
    input  logic                 a_i,
    input  logic                 b_i,
    output logic [NUM_GATES-1:0] expected_o
);

    // Ideal gate outputs for the applied (a, b), in q_in bit order
    always_comb begin
        expected_o            = '0;
        expected_o[GATE_AND]  = a_i & b_i;
        expected_o[GATE_OR]   = a_i | b_i;
        expected_o[GATE_NOTA] = ~a_i;
        expected_o[GATE_NAND] = ~(a_i & b_i);
        expected_o[GATE_NOR]  = ~(a_i | b_i);
        expected_o[GATE_XOR]  = a_i ^ b_i;
        expected_o[GATE_XNOR] = ~(a_i ^ b_i);
    end

endmodule

// File: rtl/gate_bank_checker.sv
// rtl/gate_bank_checker.sv - exhaustive two-input gate bank tester; GBC_CAPTURE_EN adds first-failure capture
module gate_bank_checker
    import gbc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 drive_a,
    output logic                 drive_b,
    input  logic [NUM_GATES-1:0] q_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] fail_mask,
    output logic [2:0]           err_cnt
`ifdef GBC_CAPTURE_EN
    ,
    output logic [8:0]           first_fail,
    output logic                 first_valid
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] VEC_LAST    = 2'(NUM_VECTORS - 1);

    gbc_state_e           state_q, state_d;
    logic [1:0]           vec_q, vec_d;
    logic [3:0]           settle_q, settle_d;
    logic                 drive_a_q, drive_a_d;
    logic                 drive_b_q, drive_b_d;
    logic [NUM_GATES-1:0] mask_q, mask_d;
    logic [2:0]           err_q, err_d;
    logic                 pass_q, pass_d;

    logic [NUM_GATES-1:0] expected;
    logic [NUM_GATES-1:0] mismatch;
    logic                 accept;
    logic                 checking;

    gate_ref_model u_ref (
        .a_i        (drive_a_q),
        .b_i        (drive_b_q),
        .expected_o (expected)
    );

    assign mismatch = q_in ^ expected;
    assign accept   = (state_q == ST_IDLE) && start;
    assign checking = (state_q == ST_CHECK);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: settle each vector, check once, advance or finish
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_DRIVE;
            ST_DRIVE: if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
            ST_CHECK: state_d = (vec_q == VEC_LAST) ? ST_DONE : ST_DRIVE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        busy = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
        done = (state_q == ST_DONE);
    end

    // Datapath next values: vector stepping, settle count, result accumulation
    always_comb begin
        vec_d     = vec_q;
        settle_d  = settle_q;
        drive_a_d = drive_a_q;
        drive_b_d = drive_b_q;
        mask_d    = mask_q;
        err_d     = err_q;
        pass_d    = pass_q;
        if (accept) begin
            vec_d     = '0;
            settle_d  = '0;
            drive_a_d = 1'b0;
            drive_b_d = 1'b0;
            mask_d    = '0;
            err_d     = '0;
            pass_d    = 1'b0;
        end else if (state_q == ST_DRIVE) begin
            settle_d = (settle_q == SETTLE_LAST) ? 4'd0 : settle_q + 4'd1;
        end else if (checking) begin
            mask_d = mask_q | mismatch;
            err_d  = err_q + 3'(|mismatch);
            if (vec_q == VEC_LAST) begin
                // Drives drop back to 0 for DONE/IDLE; verdict is ready during DONE
                vec_d     = '0;
                drive_a_d = 1'b0;
                drive_b_d = 1'b0;
                pass_d    = ((mask_q | mismatch) == '0);
            end else begin
                vec_d     = vec_q + 2'd1;
                drive_a_d = vec_d[1];
                drive_b_d = vec_d[0];
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q     <= '0;
            settle_q  <= '0;
            drive_a_q <= 1'b0;
            drive_b_q <= 1'b0;
            mask_q    <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            vec_q     <= vec_d;
            settle_q  <= settle_d;
            drive_a_q <= drive_a_d;
            drive_b_q <= drive_b_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
        end
    end

    assign drive_a   = drive_a_q;
    assign drive_b   = drive_b_q;
    assign fail_mask = mask_q;
    assign err_cnt   = err_q;
    assign pass      = pass_q;

`ifdef GBC_CAPTURE_EN
    logic [8:0] first_q;
    logic       first_valid_q;

    // Latch {a, b, q_in} of the first mismatching check in a run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q       <= '0;
            first_valid_q <= 1'b0;
        end else if (accept) begin
            first_q       <= '0;
            first_valid_q <= 1'b0;
        end else if (checking && (|mismatch) && !first_valid_q) begin
            first_q       <= {drive_a_q, drive_b_q, q_in};
            first_valid_q <= 1'b1;
        end
    end

    assign first_fail  = first_q;
    assign first_valid = first_valid_q;
`endif

endmodule
